// File: rtl/uart_fifo_pkg.sv
// Shared types for the UART FIFO bridge: FSM state encodings and byte width.
package uart_fifo_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_LAUNCH, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_CAPTURE, RX_WAIT_CLR} rx_state_t;
endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// First-word fall-through synchronous FIFO; head reads 0 when empty.
// A push on full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_ni,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head,
  output logic               full,
  output logic               empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffered CPU <-> UART core byte bridge with TX/RX FIFOs and sticky overflow flags.
// Define UART_FIFO_IRQ_EN to add the registered irq_o output.
module uart_fifo_bridge
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              cpu_wr_i,
  input  logic [BYTE_W-1:0] cpu_wr_data_i,
  input  logic              cpu_rd_i,
  output logic [BYTE_W-1:0] cpu_rd_data_o,
  input  logic              clr_flags_i,
  output logic              tx_full_o,
  output logic              tx_empty_o,
  output logic              rx_empty_o,
  output logic [CNT_W-1:0]  rx_count_o,
  output logic              tx_ovf_o,
  output logic              rx_ovf_o,
  output logic              uart_wr_o,
  output logic [BYTE_W-1:0] uart_tx_data_o,
  input  logic              uart_busy_i,
  output logic              uart_rd_o,
  input  logic [BYTE_W-1:0] uart_rx_data_i,
  input  logic              uart_valid_i
`ifdef UART_FIFO_IRQ_EN
  ,
  output logic              irq_o
`endif
);
  tx_state_t         tx_state, tx_next;
  rx_state_t         rx_state, rx_next;
  logic              tx_pop, rx_push;
  logic              tx_full, tx_fifo_empty, rx_full;
  logic [CNT_W-1:0]  tx_count;
  logic [BYTE_W-1:0] tx_head;
  logic              tx_drop, rx_drop;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_tx_fifo (
    .clk       (clk),
    .reset_ni  (reset_ni),
    .push      (cpu_wr_i),
    .push_data (cpu_wr_data_i),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_fifo_empty),
    .count     (tx_count)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_rx_fifo (
    .clk       (clk),
    .reset_ni  (reset_ni),
    .push      (rx_push),
    .push_data (uart_rx_data_i),
    .pop       (cpu_rd_i),
    .head      (cpu_rd_data_o),
    .full      (rx_full),
    .empty     (rx_empty_o),
    .count     (rx_count_o)
  );

  assign tx_full_o  = tx_full;
  assign tx_empty_o = tx_fifo_empty && (tx_state == TX_IDLE);
  assign tx_drop    = cpu_wr_i && tx_full && !tx_pop;
  assign rx_drop    = rx_push && rx_full && !cpu_rd_i;

  // Head is popped on the IDLE->LAUNCH edge so data and strobe appear together.
  always_comb begin
    tx_next   = tx_state;
    tx_pop    = 1'b0;
    uart_wr_o = 1'b0;
    case (tx_state)
      TX_IDLE: if ((tx_count != '0) && !uart_busy_i) begin
        tx_pop  = 1'b1;
        tx_next = TX_LAUNCH;
      end
      TX_LAUNCH: begin
        uart_wr_o = 1'b1;
        tx_next   = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: if (uart_busy_i)  tx_next = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!uart_busy_i) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_next   = rx_state;
    rx_push   = 1'b0;
    uart_rd_o = 1'b0;
    case (rx_state)
      RX_IDLE: if (uart_valid_i) rx_next = RX_CAPTURE;
      RX_CAPTURE: begin
        rx_push   = 1'b1;
        uart_rd_o = 1'b1;
        rx_next   = RX_WAIT_CLR;
      end
      RX_WAIT_CLR: if (!uart_valid_i) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      tx_state       <= TX_IDLE;
      rx_state       <= RX_IDLE;
      uart_tx_data_o <= '0;
      tx_ovf_o       <= 1'b0;
      rx_ovf_o       <= 1'b0;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
      if (tx_pop) uart_tx_data_o <= tx_head;
      // A new overflow beats a same-cycle clear.
      if (tx_drop)          tx_ovf_o <= 1'b1;
      else if (clr_flags_i) tx_ovf_o <= 1'b0;
      if (rx_drop)          rx_ovf_o <= 1'b1;
      else if (clr_flags_i) rx_ovf_o <= 1'b0;
    end
  end

`ifdef UART_FIFO_IRQ_EN
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) irq_o <= 1'b0;
    else           irq_o <= !rx_empty_o || tx_ovf_o || rx_ovf_o;
  end
`endif
endmodule
